// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, command bytes and
// the keyboard acknowledge code.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_BITS      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_FIN       = 3'd6
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines, plus a
// one-cycle pulse on each synchronized clock falling edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving the open-drain pair
// through active-low-enable outputs.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | lines released, ready for a command byte
// INHIBIT    | clock held low; start bit asserted in the final cycle
// REQ        | clock released, data low; wait for first device clock
// BITS       | shift d1..d7 and parity out on device falling edges
// ACK        | stop bit released; sample device ack on the 11th edge
// WAIT_IDLE  | wait for both lines to return high
// FIN        | one-cycle done (and err) pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int BIT_TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] INH_LOAD   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LOAD = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_TIMEOUT - 1);

  ps2_tx_state_e state;
  logic [TW-1:0] tmr;
  logic [8:0]    shreg;
  logic [3:0]    bit_cnt;
  logic          clk_s;
  logic          data_s;
  logic          fall;
  logic          wd_active;
  logic          progress;
  logic          wd_expire;

  ps2_line_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (clk_s),
    .data_s      (data_s),
    .fall        (fall)
  );

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Any device clock edge (or the bus going idle while waiting for it)
  // counts as progress and keeps the watchdog from firing that cycle.
  always_comb begin
    wd_active = 1'b0;
    progress  = 1'b0;
    case (state)
      ST_REQ, ST_BITS, ST_ACK: begin
        wd_active = 1'b1;
        progress  = fall;
      end
      ST_WAIT_IDLE: begin
        wd_active = 1'b1;
        progress  = fall | (clk_s & data_s);
      end
      default: begin
        wd_active = 1'b0;
        progress  = 1'b0;
      end
    endcase
  end

  assign wd_expire = wd_active && !progress && (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wd_expire) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        done        <= 1'b1;
        err         <= 1'b1;
        state       <= ST_FIN;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (tx_valid && tx_ready) begin
              shreg       <= {~^tx_data, tx_data};
              bit_cnt     <= '0;
              tmr         <= INH_LOAD;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= (INHIBIT_CYCLES == 1);
              state       <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (tmr == '0) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;
              tmr         <= START_LOAD;
              state       <= ST_REQ;
            end else begin
              if (tmr == TW'(1)) ps2_data_oe <= 1'b1;
              tmr <= tmr - TW'(1);
            end
          end
          ST_REQ: begin
            if (fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[8:1]};
              bit_cnt     <= 4'd1;
              tmr         <= BIT_LOAD;
              state       <= ST_BITS;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          ST_BITS: begin
            if (fall) begin
              tmr <= BIT_LOAD;
              // Edge 10 ends the parity bit: release data as the stop bit.
              if (bit_cnt == 4'd9) begin
                ps2_data_oe <= 1'b0;
                state       <= ST_ACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[8:1]};
                bit_cnt     <= bit_cnt + 4'd1;
              end
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          ST_ACK: begin
            if (fall) begin
              if (!data_s) begin
                tmr   <= BIT_LOAD;
                state <= ST_WAIT_IDLE;
              end else begin
                done  <= 1'b1;
                err   <= 1'b1;
                state <= ST_FIN;
              end
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_s && data_s) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else if (fall) begin
              tmr <= BIT_LOAD;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on a
// wired-AND bus and a done/err scoreboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH    = 20;
  localparam int ST_TO  = 500;
  localparam int BIT_TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST_TO),
    .BIT_TIMEOUT    (BIT_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [10:0] frame;
  } exp_t;

  exp_t exp_q[$];
  logic obs_err_q[$];
  int   obs_cyc_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lone_err = 0;
  int   long_done = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      obs_err_q.push_back(err);
      obs_cyc_q.push_back(cyc);
    end
    if (err === 1'b1 && done !== 1'b1) lone_err++;
    if (done === 1'b1 && prev_done === 1'b1) long_done++;
    prev_done = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bits as the device sees them: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Called on the negedge of the first INHIBIT cycle; returns on REQ cycle 1.
  task automatic inhibit_check(input string tag, output int req_cyc);
    int   n;
    logic d19;
    logic d20;
    n   = 0;
    d19 = 1'bx;
    d20 = 1'bx;
    check({tag, "_acc_busy"}, busy, 1);
    while (ps2_clk_oe === 1'b1 && n < 100) begin
      n++;
      if (n == INH - 1) d19 = ps2_data_oe;
      if (n == INH) d20 = ps2_data_oe;
      @(negedge clk);
    end
    check({tag, "_inh_len"}, n, INH);
    check({tag, "_inh_d19"}, d19, 0);
    check({tag, "_inh_d20"}, d20, 1);
    check({tag, "_req_data"}, ps2_data_oe, 1);
    req_cyc = cyc;
  endtask

  task automatic start_tx(input string tag, input logic [7:0] d, output int req_cyc);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    inhibit_check(tag, req_cyc);
  endtask

  task automatic device(input int n_edges, input logic ack, output logic [10:0] s);
    s = '0;
    for (int k = 0; k < n_edges; k++) begin
      repeat (20) @(negedge clk);
      s[k] = ps2_data_in;
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    if (n_edges == 11) begin
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget, input logic [10:0] s,
                           input logic chk_frame, output int dcyc);
    int   n;
    exp_t e;
    n    = 0;
    dcyc = -1;
    while (obs_err_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, obs_err_q.size() > 0, 1);
    if (obs_err_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_err"}, obs_err_q.pop_front(), e.err);
      dcyc = obs_cyc_q.pop_front();
      if (chk_frame) check({tag, "_frame"}, s, e.frame);
    end
  endtask

  initial begin
    logic [10:0] s;
    int          rc;
    int          dc;
    int          n;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Set-LED command, device acknowledges.
    exp_q.push_back({1'b0, frame_of(PS2_CMD_SET_LED)});
    start_tx("led", PS2_CMD_SET_LED, rc);
    device(11, 1'b1, s);
    wait_done("led", 200, s, 1'b1, dc);
    check("led_clk_rel", ps2_clk_oe, 0);
    check("led_data_rel", ps2_data_oe, 0);
    @(negedge clk);
    check("led_ready", tx_ready, 1);

    // All-zero byte, device leaves data high on the ack edge.
    exp_q.push_back({1'b1, frame_of(8'h00)});
    start_tx("nack", 8'h00, rc);
    device(11, 1'b0, s);
    wait_done("nack", 200, s, 1'b1, dc);
    repeat (5) @(negedge clk);

    // Device never clocks: start watchdog.
    exp_q.push_back({1'b1, 11'h000});
    start_tx("tmo", PS2_RSP_ACK, rc);
    wait_done("tmo", ST_TO + 100, s, 1'b0, dc);
    check("tmo_latency", dc - rc, ST_TO);
    check("tmo_clk_rel", ps2_clk_oe, 0);
    check("tmo_data_rel", ps2_data_oe, 0);
    repeat (5) @(negedge clk);

    // Reset after the fifth device edge; d4 of 0xA5 is 0 so data is pulled.
    start_tx("rstm", 8'hA5, rc);
    device(5, 1'b0, s);
    check("rstm_pre_data", ps2_data_oe, 1);
    check("rstm_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rstm_clk_oe", ps2_clk_oe, 0);
    check("rstm_data_oe", ps2_data_oe, 0);
    check("rstm_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rstm_no_done", obs_err_q.size(), 0);

    // Held tx_valid: enable then reset command back to back.
    exp_q.push_back({1'b0, frame_of(PS2_CMD_ENABLE)});
    exp_q.push_back({1'b0, frame_of(PS2_CMD_RESET)});
    @(negedge clk);
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = PS2_CMD_RESET;
    inhibit_check("en", rc);
    device(11, 1'b1, s);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("en_done_poll", done, 1);
    @(negedge clk);
    check("gap_idle_ready", tx_ready, 1);
    @(negedge clk);
    check("gap_reaccept_clk", ps2_clk_oe, 1);
    tx_valid = 1'b0;
    wait_done("en", 5, s, 1'b1, dc);
    inhibit_check("rs", rc);
    // Pulse while busy must be dropped.
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device(11, 1'b1, s);
    wait_done("rs", 200, s, 1'b1, dc);
    repeat (20) @(negedge clk);
    check("drop_ready", tx_ready, 1);
    check("drop_clk_oe", ps2_clk_oe, 0);
    check("drop_no_done", obs_err_q.size(), 0);
    check("drop_exp_empty", exp_q.size(), 0);

    check("err_without_done", lone_err, 0);
    check("done_width", long_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, …) to the keyboard over the same open-drain clock/data pair that the existing keyboard receiver listens on. It sits beside the receiver under top, drives the lines only through active-low-enable outputs, and holds `busy` high so the receiver can ignore line activity during a transmission.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 12000: clk cycles ps2 clock is held low before start (120 µs @ 100 MHz).
- `START_TIMEOUT`, 1500000: max cycles from clock release to the first device falling edge (15 ms).
- `BIT_TIMEOUT`, 200000: max cycles between consecutive device falling edges, and from the ACK edge to line idle (2 ms).

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in 8: byte to send, sampled on accept.
- `tx_valid` in 1: request; accepted when `tx_valid && tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `ps2_clk_in` in 1: raw ps2 clock line (asynchronous).
- `ps2_data_in` in 1: raw ps2 data line (asynchronous).
- `ps2_clk_oe` out 1: 1 = pull clock low, 0 = release.
- `ps2_data_oe` out 1: 1 = pull data low, 0 = release.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of transfer, success or failure.
- `err` out 1: valid with `done`; 1 = NACK or timeout.

## Operation
- Line inputs pass through a 2-flop synchronizer. A falling edge (`fall`) is `prev & ~cur` on the synchronized clock.
- FSM states: IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, FIN.
- IDLE: all outputs 0, `tx_ready` = 1. On accept, latch `{~^tx_data, tx_data}` into a 9-bit shift register, clear the bit counter, go to INHIBIT.
- INHIBIT: `ps2_clk_oe` = 1 for exactly INHIBIT_CYCLES cycles. In the last INHIBIT cycle, also set `ps2_data_oe` = 1 (start bit). Then go to REQ.
- REQ: `ps2_clk_oe` = 0 and `ps2_data_oe` = 1. On `fall`, drive `ps2_data_oe` = ~d0 and go to BITS.
- BITS: on each `fall`, shift to the next bit: d1..d7, then parity (9 edges total including the REQ edge). On the 10th edge, release data (stop bit) and go to ACK.
- ACK: on the 11th `fall`, sample synchronized data. Low = ack, go to WAIT_IDLE. High = NACK, go to FIN with err.
- WAIT_IDLE: wait until synchronized clock and data are both 1, then go to FIN with err = 0.
- FIN: `done` = 1 for one cycle, `err` as recorded. Go to IDLE.
- Watchdog counter reloads on every state entry and every `fall`:
  - REQ uses START_TIMEOUT.
  - BITS, ACK and WAIT_IDLE use BIT_TIMEOUT.
  - On expiry, release both lines and go to FIN with err = 1.
- Parity is odd: the parity bit equals `~^tx_data`.

## Timing
- Reset (async, immediate): state IDLE; `ps2_clk_oe`, `ps2_data_oe`, `busy`, `done`, `err` = 0; `tx_ready` = 1. A reset mid-frame releases both lines at once and does not pulse `done`.
- Accept at edge N: `busy` = 1 and `ps2_clk_oe` = 1 from edge N+1.
- `ps2_data_oe` updates 3 cycles after the raw line falls (2 sync flops + edge register). This is well inside the device low phase (≥30 µs).
- `tx_valid` while busy is ignored; no queuing.
- `tx_valid` held through FIN is accepted on the first IDLE cycle after `done`. Minimum gap between transfers is 2 cycles.
- `done` and `err` are registered outputs, each high for exactly one cycle. `err` is 0 whenever `done` is 0.
- Device clock edges arriving in INHIBIT are ignored.

## Structure
- Shared package `ps2_pkg` holds:
  - the FSM state enum;
  - command constants `PS2_CMD_SET_LED = 8'hED`, `PS2_CMD_RESET = 8'hFF`, `PS2_CMD_ENABLE = 8'hF4`;
  - `PS2_RSP_ACK = 8'hFA`.
- Sub-module `ps2_line_sync`: 2-flop synchronizers for both lines plus a falling-edge pulse on clock. The receiver reuses it.
- Top-level tristate is `inout = oe ? 1'b0 : 1'bz`, done in top, not in this block.

## Test plan
Bench uses INHIBIT_CYCLES = 20, START_TIMEOUT = 500, BIT_TIMEOUT = 200, and a device model toggling the clock every 40 cycles.
- Send 0xED, device acks → data sampled on rising edges reads 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Device pulls data low on edge 11 → `done` = 1, `err` = 0, lines released.
- `ps2_clk_oe` high for exactly 20 cycles after accept. `ps2_data_oe` rises on the 20th of those cycles; clock is released the next cycle.
- Send 0x00, device leaves data high on edge 11 → parity bit 1 observed, `done` = 1 with `err` = 1.
- Device never clocks → `done` and `err` pulse 500 cycles after REQ entry, both oe = 0.
- `rst` asserted after edge 5 → both oe drop the same cycle, no `done` pulse, `tx_ready` = 1.
- `tx_valid` held high with 0xF4 then 0xFF → first `done`, then second accept within 2 cycles. A `tx_valid` pulse while busy is dropped.
